prog_loader: RTL and testbench

Boot-time program loader and run controller for the toy CPU top level. It accepts a program image as a byte stream and packs it into instruction-memory words, writing them sequentially from address 0. It holds the CPU in reset while loading and for a programmable settle time, then releases it for a bounded or unbounded run. It replaces static memory preloading and fixed-delay run windows with a reusable, parametrised sequencer.

---
 rtl/prog_loader_if.sv | 33 +++
 rtl/prog_loader.sv | 154 +++++++++++++++
 tb/tb_prog_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Control, byte-stream and memory-write signals of the program loader.
// The loader sits on the slave side of this bundle.
interface prog_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  start;
    logic [ADDR_WIDTH:0]   len;
    logic                  stop;
    logic                  s_valid;
    logic [7:0]            s_data;
    logic                  s_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  cpu_rst;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [31:0]           cycles;

    modport master (
        output start, len, stop, s_valid, s_data,
        input  s_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_rst, busy, done, err, cycles
    );

    modport slave (
        input  start, len, stop, s_valid, s_data,
        output s_ready, mem_we, mem_addr, mem_wdata,
        output cpu_rst, busy, done, err, cycles
    );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: packs a byte stream into memory words from address 0,
// then holds the CPU in reset for a settle time and runs it.
module prog_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int BIG_ENDIAN = 1,
    parameter int RESET_HOLD = 10,
    parameter int RUN_CYCLES = 100
) (
    input logic         clk,
    input logic         rst,
    prog_loader_if.slave bus
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   widx_q, widx_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [31:0]           hold_q, hold_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  err_q, err_d;
    logic [31:0]           cycles_q, cycles_d;

    logic                  len_ok;
    logic [DATA_WIDTH-1:0] word;

    always_comb begin
        len_ok = (bus.len != '0) && (bus.len <= MAX_LEN);
        // Shift the new byte in at the end that ends up holding the last byte
        if (BIG_ENDIAN != 0)
            word = (shreg_q << 8) | DATA_WIDTH'(bus.s_data);
        else
            word = (shreg_q >> 8) | (DATA_WIDTH'(bus.s_data) << (DATA_WIDTH - 8));
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        widx_d      = widx_q;
        bcnt_d      = bcnt_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        cycles_d    = cycles_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    if (len_ok) begin
                        state_d  = LOAD;
                        len_d    = bus.len;
                        widx_d   = '0;
                        bcnt_d   = '0;
                        err_d    = 1'b0;
                        cycles_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (bus.s_valid) begin
                    shreg_d = word;
                    if (bcnt_q == BW'(BPW - 1)) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = widx_q[ADDR_WIDTH-1:0];
                        mem_wdata_d = word;
                        widx_d      = widx_q + (ADDR_WIDTH + 1)'(1);
                        bcnt_d      = '0;
                        if (widx_q == len_q - (ADDR_WIDTH + 1)'(1)) begin
                            state_d = HOLD;
                            hold_d  = 32'(RESET_HOLD);
                        end
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
            end
            HOLD: begin
                hold_d = hold_q - 32'd1;
                if (hold_q <= 32'd1)
                    state_d = RUN;
            end
            RUN: begin
                if (cycles_q != '1)
                    cycles_d = cycles_q + 32'd1;
                if (bus.stop ||
                    (RUN_CYCLES != 0 && cycles_q == 32'(RUN_CYCLES - 1)))
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        cpu_rst_d = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            widx_q      <= '0;
            bcnt_q      <= '0;
            shreg_q     <= '0;
            hold_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b1;
            err_q       <= 1'b0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            widx_q      <= widx_d;
            bcnt_q      <= bcnt_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            err_q       <= err_d;
            cycles_q    <= cycles_d;
        end
    end

    assign bus.s_ready   = (state_q == LOAD);
    assign bus.busy      = (state_q == LOAD) || (state_q == HOLD) || (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.err       = err_q;
    assign bus.cycles    = cycles_q;
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: big-endian, little-endian and unbounded-run
// instances share one byte stream; writes are checked against queues.
module tb_prog_loader;
    localparam int DW = 32;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          stop_main = 1'b0;
    logic          stop_rc = 1'b0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = '0;

    prog_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) be_if ();
    prog_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) le_if ();
    prog_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rc_if ();

    assign be_if.start = start;
    assign be_if.len = len;
    assign be_if.stop = stop_main;
    assign be_if.s_valid = s_valid;
    assign be_if.s_data = s_data;
    assign le_if.start = start;
    assign le_if.len = len;
    assign le_if.stop = stop_main;
    assign le_if.s_valid = s_valid;
    assign le_if.s_data = s_data;
    assign rc_if.start = start;
    assign rc_if.len = len;
    assign rc_if.stop = stop_rc;
    assign rc_if.s_valid = s_valid;
    assign rc_if.s_data = s_data;

    prog_loader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BIG_ENDIAN(1),
        .RESET_HOLD(10), .RUN_CYCLES(100)
    ) u_be (.clk(clk), .rst(rst), .bus(be_if));

    prog_loader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BIG_ENDIAN(0),
        .RESET_HOLD(10), .RUN_CYCLES(100)
    ) u_le (.clk(clk), .rst(rst), .bus(le_if));

    prog_loader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BIG_ENDIAN(1),
        .RESET_HOLD(10), .RUN_CYCLES(0)
    ) u_rc (.clk(clk), .rst(rst), .bus(rc_if));

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t q_be[$];
    wr_t q_le[$];

    logic [31:0] prog [4] = '{32'h34011100, 32'h34020020,
                              32'h3403ff00, 32'h3404ffff};

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int exp_gap = 4;
    int exp_last = 3;
    int last_we_cyc = 0;
    int fall_cyc = 0;
    int rise_cyc = 0;
    logic prev_cpu_rst = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        wr_t e;
        if (be_if.mem_we) begin
            if (q_be.size() == 0) begin
                chk("be_unexpected_we", be_if.mem_we, 0);
            end else begin
                e = q_be.pop_front();
                chk("be_addr", be_if.mem_addr, e.addr);
                chk("be_data", be_if.mem_wdata, e.data);
                if (e.addr != 0)
                    chk("we_gap", cyc - last_we_cyc, exp_gap);
                chk("s_ready_at_we", be_if.s_ready, int'(e.addr) != exp_last);
                last_we_cyc = cyc;
            end
        end
        if (le_if.mem_we) begin
            if (q_le.size() == 0) begin
                chk("le_unexpected_we", le_if.mem_we, 0);
            end else begin
                e = q_le.pop_front();
                chk("le_addr", le_if.mem_addr, e.addr);
                chk("le_data", le_if.mem_wdata, e.data);
            end
        end
        if (prev_cpu_rst && !be_if.cpu_rst) fall_cyc = cyc;
        if (!prev_cpu_rst && be_if.cpu_rst) rise_cyc = cyc;
        prev_cpu_rst = be_if.cpu_rst;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        mon();
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len = (AW + 1)'(l);
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        s_valid = 1'b1;
        s_data = b;
        while (!be_if.s_ready && n < 50) begin
            step();
            n++;
        end
        if (n == 50) chk("s_ready_timeout", be_if.s_ready, 1);
        step();
        s_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic load_bytes(input int nbytes, input int gap);
        wr_t e;
        logic [31:0] w;
        for (int k = 0; k < nbytes; k++) begin
            w = prog[k / 4];
            if (k % 4 == 3) begin
                e.addr = AW'(k / 4);
                e.data = w;
                q_be.push_back(e);
                e.data = {w[7:0], w[15:8], w[23:16], w[31:24]};
                q_le.push_back(e);
            end
            send_byte(w[31 - 8 * (k % 4) -: 8], gap);
        end
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!be_if.done && n < limit) begin
            stop_rc = (rc_if.cycles == 32'd36) && !rc_if.cpu_rst;
            step();
            n++;
        end
        stop_rc = 1'b0;
        chk("done_reached", be_if.done, 1);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) step();
        chk("rst_cpu_rst", be_if.cpu_rst, 1);
        chk("rst_s_ready", be_if.s_ready, 0);
        chk("rst_mem_we", be_if.mem_we, 0);
        chk("rst_busy", be_if.busy, 0);
        chk("rst_done", be_if.done, 0);
        chk("rst_err", be_if.err, 0);
        chk("rst_mem_addr", be_if.mem_addr, 0);
        chk("rst_mem_wdata", be_if.mem_wdata, 0);
        chk("rst_cycles", be_if.cycles, 0);
        rst = 1'b1;
        step();

        do_start(0);
        chk("len0_err", be_if.err, 1);
        chk("len0_busy", be_if.busy, 0);
        chk("len0_done", be_if.done, 0);
        do_start(1025);
        chk("len1025_err", be_if.err, 1);
        chk("len1025_busy", be_if.busy, 0);
        chk("len1025_s_ready", be_if.s_ready, 0);

        do_start(4);
        chk("start_err_clr", be_if.err, 0);
        chk("start_busy", be_if.busy, 1);
        chk("start_s_ready", be_if.s_ready, 1);
        chk("start_cpu_rst", be_if.cpu_rst, 1);
        exp_gap = 4;
        exp_last = 3;
        load_bytes(16, 0);
        chk("hold_s_ready", be_if.s_ready, 0);
        chk("hold_cpu_rst", be_if.cpu_rst, 1);
        wait_done(300);
        chk("run1_cycles", be_if.cycles, 100);
        chk("run1_cpu_rst", be_if.cpu_rst, 1);
        chk("run1_busy", be_if.busy, 0);
        chk("hold_len", fall_cyc - last_we_cyc, 10);
        chk("run_len", rise_cyc - fall_cyc, 100);
        chk("le_cycles", le_if.cycles, 100);
        chk("le_done", le_if.done, 1);
        chk("rc_done", rc_if.done, 1);
        chk("rc_cycles", rc_if.cycles, 37);
        chk("rc_cpu_rst", rc_if.cpu_rst, 1);

        do_start(4);
        chk("restart_cycles", be_if.cycles, 0);
        chk("restart_done", be_if.done, 0);
        chk("restart_rc_cycles", rc_if.cycles, 0);
        exp_gap = 8;
        load_bytes(16, 1);
        wait_done(400);
        chk("run2_cycles", be_if.cycles, 100);
        chk("run2_rc_cycles", rc_if.cycles, 37);

        do_start(4);
        exp_gap = 4;
        load_bytes(9, 0);
        #1 rst = 1'b0;
        #1;
        chk("arst_mem_we", be_if.mem_we, 0);
        chk("arst_mem_addr", be_if.mem_addr, 0);
        chk("arst_mem_wdata", be_if.mem_wdata, 0);
        chk("arst_cpu_rst", be_if.cpu_rst, 1);
        chk("arst_busy", be_if.busy, 0);
        chk("arst_s_ready", be_if.s_ready, 0);
        chk("arst_le_wdata", le_if.mem_wdata, 0);
        step();
        rst = 1'b1;
        step();
        do_start(2);
        exp_last = 1;
        load_bytes(8, 0);
        wait_done(300);
        chk("run3_cycles", be_if.cycles, 100);
        chk("run3_err", be_if.err, 0);

        chk("be_queue_empty", q_be.size(), 0);
        chk("le_queue_empty", q_le.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
